// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    EMIT,
    FINISH
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Collects little-endian bytes into a 32-bit instruction word.
module byte_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  logic [1:0]        idx;
  logic [WORD_W-1:0] shreg;

  // Shift each new byte in at the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (load) begin
      idx   <= idx + 2'd1;
      shreg <= {data, shreg[WORD_W-1:8]};
    end
  end

  // Flags that the byte currently being loaded completes the word.
  always_comb begin
    word = shreg;
    last = (idx == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program from a host byte port into instruction memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             w_en,
  output logic [31:0]      machineCode,
  output logic [LEN_W-1:0] word_addr,
  output logic             cpu_hold,
  output logic             done
);

  loader_state_t     state, next_state;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  hdr_count;
  logic [WORD_W-1:0] mc_hold;
  logic [WORD_W-1:0] asm_word;
  logic              asm_last;
  logic              asm_load;
  logic              asm_clear;
  logic              xfer;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_count = LEN_W'({byte_data, len_lo});

  byte_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (asm_clear),
    .load  (asm_load),
    .data  (byte_data),
    .word  (asm_word),
    .last  (asm_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LEN_LO;
      LEN_LO:  if (xfer) next_state = LEN_HI;
      LEN_HI:  if (xfer) next_state = (hdr_count == '0) ? FINISH : DATA;
      DATA:    if (xfer && asm_last) next_state = EMIT;
      EMIT:    next_state = (count == LEN_W'(1)) ? FINISH : DATA;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs plus assembler strobes; machineCode shows the live word only in EMIT.
  always_comb begin
    byte_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    w_en        = (state == EMIT);
    done        = (state == FINISH);
    cpu_hold    = (state != IDLE);
    machineCode = (state == EMIT) ? asm_word : mc_hold;
    asm_load    = (state == DATA) && xfer;
    asm_clear   = (state == IDLE) && start;
  end

  // Header, address and remaining-count bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo    <= '0;
      count     <= '0;
      word_addr <= '0;
      mc_hold   <= '0;
    end else begin
      case (state)
        IDLE:    if (start) word_addr <= '0;
        LEN_LO:  if (xfer) len_lo <= byte_data;
        LEN_HI:  if (xfer) count <= hdr_count;
        EMIT: begin
          mc_hold   <= asm_word;
          word_addr <= word_addr + LEN_W'(1);
          count     <= count - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: LEN_W, 16, width of the word-count header and word_addr.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 byte_valid  input  1  host byte stream valid.
REQ-006 byte_data  input  8  host byte.
REQ-007 byte_ready  output  1  loader accepts byte_data this cycle when byte_valid is also high.
REQ-008 w_en  output  1  instruction-memory write strobe to the CPU.
REQ-009 machineCode  output  32  instruction word written when w_en is high.
REQ-010 word_addr  output  LEN_W  word index of the current write, starting at 0.
REQ-011 cpu_hold  output  1  holds the CPU pipeline stalled while a load is in progress.
REQ-012 done  output  1  one-cycle pulse at load completion.

Function
REQ-013 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high; byte_data SHALL be ignored otherwise.
REQ-014 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, EMIT, FINISH.
REQ-015 IDLE: start=1 SHALL move to LEN_LO next cycle; start SHALL be ignored in every other state.
REQ-016 LEN_LO/LEN_HI SHALL each consume one byte forming count = {hi,lo} (little-endian), truncated to LEN_W bits.
REQ-017 After LEN_HI, count==0 SHALL go directly to FINISH with no w_en pulse; otherwise SHALL go to DATA.
REQ-018 DATA SHALL consume 4 bytes little-endian (first byte to bits 7:0); after the 4th byte SHALL go to EMIT.
REQ-019 EMIT SHALL last exactly one cycle with w_en=1, machineCode=assembled word, word_addr=current index, byte_ready=0.
REQ-020 After EMIT, word_addr SHALL increment by 1 and remaining count decrement by 1; remaining==0 SHALL go to FINISH, else DATA.
REQ-021 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-022 byte_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA.
REQ-023 cpu_hold SHALL be 1 in every state except IDLE, including the FINISH cycle.
REQ-024 machineCode SHALL hold its last emitted value outside EMIT; w_en SHALL be 0 outside EMIT.
REQ-025 Byte stalls (byte_valid low) of any length SHALL pause progress without losing assembled bytes.
REQ-026 Maximum load of 2^LEN_W-1 words SHALL complete with word_addr ending at 2^LEN_W-2 on the final EMIT.

Reset
REQ-027 rst high SHALL force IDLE, w_en=0, done=0, cpu_hold=0, byte_ready=0, machineCode=0, word_addr=0, count=0, partial word cleared.
REQ-028 rst asserted mid-load SHALL abort immediately with no further w_en; a new load SHALL require a fresh start after rst deasserts.

Structure
REQ-029 The FSM state enum (loader_state_t) and the byte-per-word constant (4) SHALL live in the shared CPU package.
REQ-030 One sub-module, byte_assembler (2-bit byte index plus 32-bit shift register, clear and load inputs), SHALL hold the partial word.

Verification
REQ-031 start, bytes 02 00 13 00 00 00 93 00 10 00 -> w_en at addr 0 with 0x00000013, at addr 1 with 0x00100093, then done pulse, cpu_hold low next cycle.
REQ-032 start, bytes 00 00 -> no w_en, done pulses the cycle after LEN_HI, cpu_hold high from LEN_LO through FINISH.
REQ-033 count 1, byte_valid toggled 1/0 every cycle -> single write of correct word; byte_ready low during EMIT even with byte_valid high.
REQ-034 start pulsed while in DATA -> ignored; word sequence and addresses unchanged.
REQ-035 rst asserted after 2 of 4 data bytes -> all outputs zero asynchronously, no w_en; subsequent start with count 1 writes the new word at addr 0.
REQ-036 LEN_W=4, count 0x000F -> 15 writes, addresses 0..14, then done.
